imul_result_accum: RTL

//   Downstream consumer of the integer multiplier's 32-bit product stream.

---
 rtl/imul_result_accum_if.sv | 25 ++
 rtl/imul_result_accum.sv | 53 +++++
 2 files changed

// File: rtl/imul_result_accum_if.sv
// imul_result_accum_if: config, product and sum val/rdy streams of the batch accumulator.
interface imul_result_accum_if #(
   parameter int p_nbits     = 32,
   parameter int p_len_nbits = 16
);
   logic                   cfg_val;
   logic                   cfg_rdy;
   logic [p_len_nbits-1:0] cfg_msg;
   logic                   istream_val;
   logic                   istream_rdy;
   logic [p_nbits-1:0]     istream_msg;
   logic                   ostream_val;
   logic                   ostream_rdy;
   logic [p_nbits-1:0]     ostream_msg;

   modport master (
      output cfg_val, cfg_msg, istream_val, istream_msg, ostream_rdy,
      input  cfg_rdy, istream_rdy, ostream_val, ostream_msg
   );

   modport slave (
      input  cfg_val, cfg_msg, istream_val, istream_msg, ostream_rdy,
      output cfg_rdy, istream_rdy, ostream_val, ostream_msg
   );
endinterface

// File: rtl/imul_result_accum.sv
// imul_result_accum: sums a configured number of consecutive products and emits one total per batch.
module imul_result_accum #(
   parameter int p_nbits     = 32,
   parameter int p_len_nbits = 16
) (
   input logic clk,
   input logic reset,
   imul_result_accum_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                 state, state_n;
   logic [p_len_nbits-1:0] count, count_n;
   logic [p_nbits-1:0]     sum, sum_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         count <= '0;
         sum   <= '0;
      end else begin
         state <= state_n;
         count <= count_n;
         sum   <= sum_n;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      sum_n   = sum;
      case (state)
         IDLE: if (bus.cfg_val) begin
            sum_n   = '0;
            count_n = bus.cfg_msg;
            state_n = (bus.cfg_msg != '0) ? ACCUM : DONE;
         end
         ACCUM: if (bus.istream_val) begin
            sum_n   = sum + bus.istream_msg;
            count_n = count - 1'b1;
            state_n = (count == 1) ? DONE : ACCUM;
         end
         DONE: if (bus.ostream_rdy) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // handshake outputs come from state alone so no val->rdy combinational path exists
   assign bus.cfg_rdy     = (state == IDLE);
   assign bus.istream_rdy = (state == ACCUM);
   assign bus.ostream_val = (state == DONE);
   assign bus.ostream_msg = sum;
endmodule
